// File: rtl/cpu_regfile_scoreboard_if.sv
// Bundle for the register file: decode-side reads and reservations, the two
// writeback ports, and the clear engine handshake. The master modport is the
// datapath side and the slave modport is the register file.
interface cpu_regfile_scoreboard_if #(
    parameter int DATA_WIDTH          = 8,
    parameter int NUMBER_OF_REGISTERS = 8
);
    localparam int AW = $clog2(NUMBER_OF_REGISTERS);

    // ALU writeback port
    logic                         alu_write_enable_in;
    logic [AW-1:0]                alu_write_address_in;
    logic signed [DATA_WIDTH-1:0] alu_write_data_in;

    // Load writeback port (also retires the reservation)
    logic                         load_write_enable_in;
    logic [AW-1:0]                load_write_address_in;
    logic signed [DATA_WIDTH-1:0] load_write_data_in;

    // Reservation from decode when a load issues
    logic                         reserve_enable_in;
    logic [AW-1:0]                reserve_address_in;

    // Two combinational read ports with scoreboard status
    logic [AW-1:0]                read_register_address1_in;
    logic [AW-1:0]                read_register_address2_in;
    logic signed [DATA_WIDTH-1:0] read_data1_out;
    logic signed [DATA_WIDTH-1:0] read_data2_out;
    logic                         busy1_out;
    logic                         busy2_out;

    // Sequential clear engine
    logic                         clear_start_in;
    logic                         clear_busy_out;
    logic                         clear_done_out;

    modport master (
        output alu_write_enable_in, alu_write_address_in, alu_write_data_in,
        output load_write_enable_in, load_write_address_in, load_write_data_in,
        output reserve_enable_in, reserve_address_in,
        output read_register_address1_in, read_register_address2_in,
        output clear_start_in,
        input  read_data1_out, read_data2_out, busy1_out, busy2_out,
        input  clear_busy_out, clear_done_out
    );

    modport slave (
        input  alu_write_enable_in, alu_write_address_in, alu_write_data_in,
        input  load_write_enable_in, load_write_address_in, load_write_data_in,
        input  reserve_enable_in, reserve_address_in,
        input  read_register_address1_in, read_register_address2_in,
        input  clear_start_in,
        output read_data1_out, read_data2_out, busy1_out, busy2_out,
        output clear_busy_out, clear_done_out
    );
endinterface

// File: rtl/cpu_regfile_scoreboard.sv
// Two-write, two-read CPU register file with r0 hardwired to zero, a
// per-register load scoreboard, and a sequential clear engine that zeroes
// r1..rN-1 one register per cycle without using reset.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// to the read ports (load data over ALU data, never for r0, never while the
// clear engine is running). Busy bits are never forwarded.
module cpu_regfile_scoreboard #(
    parameter int DATA_WIDTH          = 8,
    parameter int NUMBER_OF_REGISTERS = 8
) (
    input logic                    clock_in,
    input logic                    reset_in,
    cpu_regfile_scoreboard_if.slave bus
);
    localparam int AW = $clog2(NUMBER_OF_REGISTERS);

    typedef logic [AW-1:0]                addr_t;
    typedef logic signed [DATA_WIDTH-1:0] data_t;
    typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DONE} state_t;

    localparam addr_t FIRST_IDX = AW'(1);
    localparam addr_t LAST_IDX  = AW'(NUMBER_OF_REGISTERS - 1);

    data_t                          regs_q [NUMBER_OF_REGISTERS];
    data_t                          regs_d [NUMBER_OF_REGISTERS];
    logic [NUMBER_OF_REGISTERS-1:0] busy_q, busy_d;
    state_t                         state_q, state_d;
    addr_t                          idx_q, idx_d;

    // Combinational read of one port: array contents, optionally overridden by
    // a write landing on this edge.
    function automatic data_t read_port(input addr_t a);
        data_t v;
        v = (a == '0) ? '0 : regs_q[a];
`ifdef REGFILE_BYPASS_EN
        if (state_q == ST_IDLE && a != '0) begin
            if (bus.load_write_enable_in && bus.load_write_address_in == a)
                v = bus.load_write_data_in;
            else if (bus.alu_write_enable_in && bus.alu_write_address_in == a)
                v = bus.alu_write_data_in;
        end
`endif
        return v;
    endfunction

    // Next-state for the array, scoreboard and clear engine.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned and no latch is inferred.
        regs_d  = regs_q;
        busy_d  = busy_q;
        state_d = state_q;
        idx_d   = idx_q;

        unique case (state_q)
            ST_IDLE: begin
                // Load is applied after ALU so it wins an address collision.
                if (bus.alu_write_enable_in && bus.alu_write_address_in != '0)
                    regs_d[bus.alu_write_address_in] = bus.alu_write_data_in;
                if (bus.load_write_enable_in && bus.load_write_address_in != '0) begin
                    regs_d[bus.load_write_address_in] = bus.load_write_data_in;
                    busy_d[bus.load_write_address_in] = 1'b0;
                end
                // Reservation applied last so a same-edge retire cannot drop it.
                if (bus.reserve_enable_in && bus.reserve_address_in != '0)
                    busy_d[bus.reserve_address_in] = 1'b1;
                if (bus.clear_start_in) begin
                    state_d = ST_CLEAR;
                    idx_d   = FIRST_IDX;
                end
            end
            ST_CLEAR: begin
                regs_d[idx_q] = '0;
                busy_d[idx_q] = 1'b0;
                if (idx_q == LAST_IDX) state_d = ST_DONE;
                else                   idx_d   = idx_q + FIRST_IDX;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = FIRST_IDX;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = FIRST_IDX;
            end
        endcase
    end

    // State registers; reset clears the whole array so reads are zero at once.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            // NOTE: the array is reset deliberately: reads must return zero while reset is held, so this stays a flop array, not a RAM.
            for (int i = 0; i < NUMBER_OF_REGISTERS; i++) regs_q[i] <= '0;
            busy_q  <= '0;
            state_q <= ST_IDLE;
            idx_q   <= FIRST_IDX;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d.
            regs_q  <= regs_d;
            busy_q  <= busy_d;
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Read ports, scoreboard status and clear engine status.
    always_comb begin
        bus.read_data1_out = read_port(bus.read_register_address1_in);
        bus.read_data2_out = read_port(bus.read_register_address2_in);
        bus.busy1_out      = (bus.read_register_address1_in != '0) &&
                             busy_q[bus.read_register_address1_in];
        bus.busy2_out      = (bus.read_register_address2_in != '0) &&
                             busy_q[bus.read_register_address2_in];
        bus.clear_busy_out = (state_q != ST_IDLE);
        bus.clear_done_out = (state_q == ST_DONE);
    end
endmodule
